// File: rtl/csr_gpio_unit.sv
// -----------------------------------------------------------------------------
// csr_gpio_unit
//
// CSR responder for the csrrw path of the 3-stage core. It implements two
// GPIO CSRs:
//   IO0_ADDR (default 0xF00) : read-only view of the synchronized switches
//   IO2_ADDR (default 0xF02) : read/write display register
// Every access returns the pre-write CSR value one cycle later (WB stage).
// Accesses to any other address set a sticky error flag.
//
// Optional feature macro: CSR_HEX_DECODE_EN
//   defined   : hex_seg is a registered 7-segment decode of io2_out
//   undefined : hex_seg is tied to all-ones (every segment off)
//
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   csr_valid_EX  in   a csrrw occupies EX this cycle
//   GPIO_we_EX    in   write enable from the control unit
//   csr_addr_EX   in   CSR address (imm12)
//   csr_wdata_EX  in   rs1 value to write
//   sw_in         in   raw asynchronous switches
//   err_clr       in   clears csr_err (a same-cycle set wins)
//   csr_rdata_WB  out  old CSR value, registered
//   io2_out       out  current io2 register
//   io2_update    out  one-cycle pulse per io2 write
//   sw_change     out  one-cycle pulse when the synchronized switches change
//   csr_err       out  sticky unmapped-address flag
//   hex_seg       out  eight active-low 7-seg digits, digit 0 in bits [6:0]
// -----------------------------------------------------------------------------
module csr_gpio_unit #(
    parameter int          DATA_W      = 32,
    parameter int          SW_W        = 18,
    parameter int          SYNC_STAGES = 2,
    parameter logic [11:0] IO0_ADDR    = 12'hF00,
    parameter logic [11:0] IO2_ADDR    = 12'hF02
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              csr_valid_EX,
    input  logic              GPIO_we_EX,
    input  logic [11:0]       csr_addr_EX,
    input  logic [DATA_W-1:0] csr_wdata_EX,
    input  logic [SW_W-1:0]   sw_in,
    input  logic              err_clr,
    output logic [DATA_W-1:0] csr_rdata_WB,
    output logic [DATA_W-1:0] io2_out,
    output logic              io2_update,
    output logic              sw_change,
    output logic              csr_err,
    output logic [55:0]       hex_seg
);

    // -------------------------------------------------------------------------
    // Switch synchronizer: SYNC_STAGES flops, then a previous-value copy used
    // for change detection.
    // -------------------------------------------------------------------------
    logic [SW_W-1:0] r_sync [SYNC_STAGES];
    logic [SW_W-1:0] r_sw_prev;
    logic            r_sw_change;
    logic [SW_W-1:0] w_sw_sync;

    assign w_sw_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= sw_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_prev   <= '0;
            r_sw_change <= 1'b0;
        end else begin
            r_sw_prev   <= w_sw_sync;
            r_sw_change <= (w_sw_sync != r_sw_prev);
        end
    end

    // -------------------------------------------------------------------------
    // EX stage: address decode, read mux and write qualification
    // -------------------------------------------------------------------------
    logic              w_hit_io0;
    logic              w_hit_io2;
    logic              w_err_set;
    logic              w_io2_wr;
    logic [DATA_W-1:0] w_rdata_nxt;
    logic [DATA_W-1:0] r_io2;

    assign w_hit_io0 = (csr_addr_EX == IO0_ADDR);
    assign w_hit_io2 = (csr_addr_EX == IO2_ADDR);

    // Unmapped accesses flag an error regardless of the write enable.
    assign w_err_set = csr_valid_EX & ~w_hit_io0 & ~w_hit_io2;

    // Only io2 is writable; a write aimed at io0 simply falls through here.
    assign w_io2_wr  = csr_valid_EX & GPIO_we_EX & w_hit_io2;

    // Read mux sees r_io2 before this cycle's write lands, which gives
    // csrrw its read-old-value semantics without extra storage.
    always_comb begin
        w_rdata_nxt = '0;
        if (csr_valid_EX) begin
            if (w_hit_io0) begin
                w_rdata_nxt = DATA_W'(w_sw_sync);
            end else if (w_hit_io2) begin
                w_rdata_nxt = r_io2;
            end
        end
    end

    // -------------------------------------------------------------------------
    // EX -> WB boundary: read data, io2 state, pulse and error flag
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] r_rdata;
    logic              r_io2_update;
    logic              r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_rdata_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_io2        <= '0;
            r_io2_update <= 1'b0;
        end else begin
            r_io2_update <= w_io2_wr;
            if (w_io2_wr) begin
                r_io2 <= csr_wdata_EX;
            end
        end
    end

    // Set has priority so an error raised in the same cycle as a clear is
    // never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Display decode (optional)
    // -------------------------------------------------------------------------
`ifdef CSR_HEX_DECODE_EN
    // Active-low segments, field order g..a (bit 6 = g, bit 0 = a).
    function automatic logic [6:0] f_hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Eight digits cover 32 bits; narrower/wider io2 is zero-extended/truncated.
    logic [31:0] w_hex_src;
    logic [55:0] r_hex;

    assign w_hex_src = 32'(r_io2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hex <= {8{7'h40}};
        end else begin
            for (int d = 0; d < 8; d++) begin
                r_hex[d*7 +: 7] <= f_hex7(w_hex_src[d*4 +: 4]);
            end
        end
    end

    assign hex_seg = r_hex;
`else
    assign hex_seg = 56'hFF_FFFF_FFFF_FFFF;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign csr_rdata_WB = r_rdata;
    assign io2_out      = r_io2;
    assign io2_update   = r_io2_update;
    assign sw_change    = r_sw_change;
    assign csr_err      = r_err;

endmodule

// File: tb/tb_csr_gpio_unit.sv
module tb_csr_gpio_unit;

    localparam int DW = 32;
    localparam int SW = 18;
    localparam int S  = 2;

    logic          clk;
    logic          rst_n;
    logic          csr_valid_EX;
    logic          GPIO_we_EX;
    logic [11:0]   csr_addr_EX;
    logic [DW-1:0] csr_wdata_EX;
    logic [SW-1:0] sw_in;
    logic          err_clr;
    logic [DW-1:0] csr_rdata_WB;
    logic [DW-1:0] io2_out;
    logic          io2_update;
    logic          sw_change;
    logic          csr_err;
    logic [55:0]   hex_seg;

    csr_gpio_unit #(
        .DATA_W(DW), .SW_W(SW), .SYNC_STAGES(S),
        .IO0_ADDR(12'hF00), .IO2_ADDR(12'hF02)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .csr_valid_EX(csr_valid_EX), .GPIO_we_EX(GPIO_we_EX),
        .csr_addr_EX(csr_addr_EX), .csr_wdata_EX(csr_wdata_EX),
        .sw_in(sw_in), .err_clr(err_clr),
        .csr_rdata_WB(csr_rdata_WB), .io2_out(io2_out),
        .io2_update(io2_update), .sw_change(sw_change),
        .csr_err(csr_err), .hex_seg(hex_seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] rdata;
        logic [DW-1:0] io2;
        logic          upd;
        logic          err;
        logic          swc;
        logic [55:0]   hex;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model state
    logic [DW-1:0] m_io2;
    logic          m_err;
    logic [SW-1:0] hist [S+2];   // hist[j] = switch value driven j cycles ago

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [55:0] hex_of(input logic [31:0] v);
        logic [55:0] r;
`ifdef CSR_HEX_DECODE_EN
        for (int d = 0; d < 8; d++) r[d*7 +: 7] = seg_tab[v[d*4 +: 4]];
`else
        r = {56{1'b1}};
        if (v == 32'h0) r = {56{1'b1}};
`endif
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic model_reset();
        m_io2 = '0;
        m_err = 1'b0;
        for (int j = 0; j < S + 2; j++) hist[j] = '0;
    endtask

    // Drives one EX cycle (called at a falling edge), records what the WB
    // outputs must look like after the next rising edge, then waits a cycle.
    task automatic step(input logic v, input logic we, input logic [11:0] a,
                        input logic [DW-1:0] wd, input logic clr, input logic [SW-1:0] sw);
        exp_t e;
        csr_valid_EX = v;
        GPIO_we_EX   = we;
        csr_addr_EX  = a;
        csr_wdata_EX = wd;
        err_clr      = clr;
        sw_in        = sw;
        for (int j = S + 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = sw;
        e.hex   = hex_of(m_io2);
        e.swc   = (hist[S] != hist[S+1]);
        if (!v)               e.rdata = '0;
        else if (a == 12'hF00) e.rdata = DW'(hist[S]);
        else if (a == 12'hF02) e.rdata = m_io2;
        else                  e.rdata = '0;
        e.upd = v && we && (a == 12'hF02);
        if (e.upd) m_io2 = wd;
        e.io2 = m_io2;
        if (v && a != 12'hF00 && a != 12'hF02) m_err = 1'b1;
        else if (clr)                         m_err = 1'b0;
        e.err = m_err;
        q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compares every WB cycle that has an expectation queued.
    always @(posedge clk) begin
        #1;
        if (rst_n && q.size() > 0) begin
            mon_e = q.pop_front();
            chk("rdata",      64'(csr_rdata_WB), 64'(mon_e.rdata));
            chk("io2_out",    64'(io2_out),      64'(mon_e.io2));
            chk("io2_update", 64'(io2_update),   64'(mon_e.upd));
            chk("csr_err",    64'(csr_err),      64'(mon_e.err));
            chk("sw_change",  64'(sw_change),    64'(mon_e.swc));
            chk("hex_seg",    64'(hex_seg),      64'(mon_e.hex));
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rdata"}, 64'(csr_rdata_WB), 64'h0);
        chk({tag, "_io2"},   64'(io2_out),      64'h0);
        chk({tag, "_upd"},   64'(io2_update),   64'h0);
        chk({tag, "_err"},   64'(csr_err),      64'h0);
        chk({tag, "_swc"},   64'(sw_change),    64'h0);
        chk({tag, "_hex"},   64'(hex_seg),      64'(hex_of(32'h0)));
    endtask

    logic [SW-1:0] sw_cur;
    logic [11:0]   addr_tab [5] = '{12'hF00, 12'hF02, 12'hF01, 12'h300, 12'hF02};

    initial begin
        rst_n = 1'b0;
        csr_valid_EX = 1'b0; GPIO_we_EX = 1'b0; csr_addr_EX = '0;
        csr_wdata_EX = '0;   sw_in = '0;        err_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;
        model_reset();

        // Write then read-old on back-to-back io2 writes
        step(1, 1, 12'hF02, 32'h1234_5678, 0, '0);
        step(1, 1, 12'hF02, 32'h0000_00AB, 0, '0);
        step(0, 0, 12'h000, 32'h0,         0, '0);

        // Switch read plus dropped write to io0
        sw_cur = 18'h2A5A5;
        repeat (5) step(0, 0, 12'h000, 32'h0, 0, sw_cur);
        step(1, 1, 12'hF00, 32'hFFFF_FFFF, 0, sw_cur);
        step(0, 0, 12'h000, 32'h0, 0, sw_cur);

        // Unmapped access, set-wins-over-clear, then clear
        step(1, 1, 12'hF01, 32'h1,  0, sw_cur);
        step(1, 0, 12'h300, 32'h0,  1, sw_cur);
        step(0, 0, 12'h000, 32'h0,  1, sw_cur);

        // Write enable without a valid access
        step(0, 1, 12'hF02, 32'hCAFE_F00D, 0, sw_cur);

        // Display value for the decoder
        step(1, 1, 12'hF02, 32'h0000_00F0, 0, sw_cur);
        repeat (2) step(0, 0, 12'h000, 32'h0, 0, sw_cur);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) sw_cur = SW'($urandom);
            step(($urandom_range(0, 3) != 0), 1'($urandom), addr_tab[$urandom_range(0, 4)],
                 $urandom, ($urandom_range(0, 7) == 0), sw_cur);
        end

        // Asynchronous reset landing on a write
        step(1, 1, 12'hF02, 32'h5555_5555, 0, sw_cur);
        csr_valid_EX = 1'b1; GPIO_we_EX = 1'b1; csr_addr_EX = 12'hF02;
        csr_wdata_EX = 32'hDEAD_BEEF; err_clr = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1, 0, 12'hF02, 32'h0, 0, sw_cur);
        repeat (5) step(0, 0, 12'h000, 32'h0, 0, sw_cur);
        step(1, 1, 12'hF00, 32'h0, 0, sw_cur);
        step(0, 0, 12'h000, 32'h0, 0, sw_cur);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Backstop so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
